rf_exec_writeback: RTL

- Multi-cycle R-type execute/write-back sequencer that sits directly downstream of the 32x32 register file and closes the loop back into it.
- Accepts one 32-bit R-type instruction per valid/ready handshake and drives the register-file read selects.
- Latches the two read operands, computes the ALU result and flags, then drives the register-file write port for exactly one cycle.

---
 rtl/rf_exec_writeback.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rf_exec_writeback.sv
// ---------------------------------------------------------------------------
// rf_exec_writeback
//
// Multi-cycle R-type execute / write-back sequencer. It sits downstream of a
// 32x32 register file and closes the loop back into it. One instruction is
// accepted per valid/ready handshake. The block then walks
// IDLE -> READ -> EXEC -> WB -> IDLE, so it handles one instruction every
// four cycles.
//
// Ports:
//   clk           system clock, all state on the rising edge
//   rst           asynchronous, active-low reset
//   instrValid    instr holds a valid instruction
//   instrReady    block accepts an instruction on this edge (IDLE only)
//   instr         opcode[31:26] rs[25:21] rt[20:16] rd[15:11]
//                 shamt[10:6] funct[5:0]
//   regReadSel0/1 register-file read selects (rs / rt of the held instruction)
//   regReadData0/1 combinational register-file read data
//   regWriteSel   register-file write select (rd)
//   writeEnable   one-cycle write strobe in WB (legal and rd != 0)
//   writeData     ALU result
//   done          one-cycle pulse in WB
//   illegal       one-cycle pulse in WB for an unsupported instruction
//   flagZ/N/C/V   flags of the last legal instruction
//
// Every output comes straight from a flop. The flops all reset
// asynchronously, so writeEnable drops as soon as rst goes low.
// ---------------------------------------------------------------------------
module rf_exec_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instrValid,
    output logic              instrReady,
    input  logic [31:0]       instr,
    output logic [ADDR_W-1:0] regReadSel0,
    output logic [ADDR_W-1:0] regReadSel1,
    input  logic [DATA_W-1:0] regReadData0,
    input  logic [DATA_W-1:0] regReadData1,
    output logic [ADDR_W-1:0] regWriteSel,
    output logic              writeEnable,
    output logic [DATA_W-1:0] writeData,
    output logic              done,
    output logic              illegal,
    output logic              flagZ,
    output logic              flagN,
    output logic              flagC,
    output logic              flagV
);

    localparam int MSB = DATA_W - 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              c;
        logic              v;
    } alu_out_t;

    // Decide whether opcode/funct name one of the supported R-type operations.
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        if (op == OP_RTYPE) begin
            case (fn)
                FN_SLL, FN_SRL, FN_ADD, FN_SUB,
                FN_AND, FN_OR, FN_XOR, FN_SLT: ok = 1'b1;
                default:                       ok = 1'b0;
            endcase
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Compute the result plus the carry and overflow flags. Both flags are 0
    // for everything except ADD and SUB.
    function automatic alu_out_t alu(input logic [5:0]        fn,
                                     input logic [4:0]        shamt,
                                     input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b);
        alu_out_t        o;
        logic [DATA_W:0] wide;
        o    = '0;
        wide = {(DATA_W+1){1'b0}};
        case (fn)
            FN_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                o.res = wide[MSB:0];
                o.c   = wide[DATA_W];
                o.v   = (a[MSB] == b[MSB]) && (o.res[MSB] != a[MSB]);
            end
            FN_SUB: begin
                // A + ~B + 1: the carry out of this sum is the not-borrow flag.
                wide  = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
                o.res = wide[MSB:0];
                o.c   = wide[DATA_W];
                o.v   = (a[MSB] != b[MSB]) && (o.res[MSB] != a[MSB]);
            end
            FN_AND: o.res = a & b;
            FN_OR:  o.res = a | b;
            FN_XOR: o.res = a ^ b;
            FN_SLT: o.res = ($signed(a) < $signed(b)) ? {{(DATA_W-1){1'b0}}, 1'b1}
                                                      : {DATA_W{1'b0}};
            FN_SLL: o.res = b << shamt;
            FN_SRL: o.res = b >> shamt;
            default: o.res = {DATA_W{1'b0}};
        endcase
        return o;
    endfunction

    state_t            state_q,   state_d;
    logic [31:0]       instr_q,   instr_d;
    logic [DATA_W-1:0] a_q,       a_d;
    logic [DATA_W-1:0] b_q,       b_d;
    logic [DATA_W-1:0] result_q,  result_d;
    logic              ready_q,   ready_d;
    logic              we_q,      we_d;
    logic              done_q,    done_d;
    logic              illegal_q, illegal_d;
    logic [3:0]        flags_q,   flags_d;   // {Z, N, C, V}

    logic [5:0] fld_op;
    logic [4:0] fld_rs;
    logic [4:0] fld_rt;
    logic [4:0] fld_rd;
    logic [4:0] fld_shamt;
    logic [5:0] fld_fn;
    logic       legal_s;
    alu_out_t   alu_s;

    assign fld_op    = instr_q[31:26];
    assign fld_rs    = instr_q[25:21];
    assign fld_rt    = instr_q[20:16];
    assign fld_rd    = instr_q[15:11];
    assign fld_shamt = instr_q[10:6];
    assign fld_fn    = instr_q[5:0];

    assign legal_s = is_legal(fld_op, fld_fn);
    assign alu_s   = alu(fld_fn, fld_shamt, a_q, b_q);

    // Next-state and next-output logic for the four-state sequencer.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        ready_d   = ready_q;
        we_d      = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        flags_d   = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (instrValid) begin
                    instr_d = instr;
                    state_d = ST_READ;
                    ready_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            ST_READ: begin
                a_d     = regReadData0;
                b_d     = regReadData1;
                state_d = ST_EXEC;
                ready_d = 1'b0;
            end
            ST_EXEC: begin
                // The WB-cycle outputs are set up here, so that they come
                // out of flops during WB.
                result_d  = alu_s.res;
                state_d   = ST_WB;
                ready_d   = 1'b0;
                done_d    = 1'b1;
                illegal_d = ~legal_s;
                we_d      = legal_s && (fld_rd != 5'd0);
                if (legal_s) begin
                    flags_d = {(alu_s.res == {DATA_W{1'b0}}), alu_s.res[MSB], alu_s.c, alu_s.v};
                end else begin
                    flags_d = flags_q;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers. The asynchronous reset aborts any
    // instruction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            instr_q   <= 32'h0000_0000;
            a_q       <= {DATA_W{1'b0}};
            b_q       <= {DATA_W{1'b0}};
            result_q  <= {DATA_W{1'b0}};
            ready_q   <= 1'b1;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            flags_q   <= 4'b0000;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            flags_q   <= flags_d;
        end
    end

    assign instrReady  = ready_q;
    assign regReadSel0 = ADDR_W'(fld_rs);
    assign regReadSel1 = ADDR_W'(fld_rt);
    assign regWriteSel = ADDR_W'(fld_rd);
    assign writeEnable = we_q;
    assign writeData   = result_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign flagZ       = flags_q[3];
    assign flagN       = flags_q[2];
    assign flagC       = flags_q[1];
    assign flagV       = flags_q[0];

endmodule
